// File: rtl/timer_scheduler_if.sv
// Command port of the millisecond timer service: ARM/CANCEL requests from a
// requester (master) to the scheduler (slave), plus ready and error feedback.
interface timer_scheduler_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_op;
  logic [3:0]       cmd_ch;
  logic [CNT_W-1:0] cmd_ms;
  logic             cmd_periodic;
  logic             cmd_err;

  modport master (
    output cmd_valid, cmd_op, cmd_ch, cmd_ms, cmd_periodic,
    input  cmd_ready, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ch, cmd_ms, cmd_periodic,
    output cmd_ready, cmd_err
  );
endinterface

// File: rtl/timer_scheduler.sv
// Multi-channel millisecond timer: prescaler tick, one-channel-per-cycle sweep.
// Optional uptime counters enabled by defining TIMER_SCHEDULER_UPTIME_EN.
//
// state   | meaning
// S_IDLE  | accepting commands; leaves on a pending tick
// S_SWEEP | processes channel idx_q this cycle
// S_DONE  | one settling cycle before commands reopen
module timer_scheduler #(
  parameter int CLOCK_HZ = 25000000,
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  timer_scheduler_if.slave    cmd,
  output logic                tick_ms,
  output logic [NUM_CH-1:0]   expired,
  output logic [NUM_CH-1:0]   active
`ifdef TIMER_SCHEDULER_UPTIME_EN
  ,
  output logic [9:0]          uptime_ms,
  output logic [7:0]          uptime_s
`endif
);

  localparam int DIV   = CLOCK_HZ / 1000;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic [PRE_W-1:0]             pre_q, pre_d;
  logic                         tick_q, tick_d;
  logic                         pend_q, pend_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [NUM_CH-1:0]            act_q, act_d;
  logic [NUM_CH-1:0]            per_q, per_d;
  logic [NUM_CH-1:0][CNT_W-1:0] remain_q, remain_d;
  logic [NUM_CH-1:0][CNT_W-1:0] reload_q, reload_d;
  logic [NUM_CH-1:0]            expired_q, expired_d;
  logic                         err_q, err_d;
  logic                         ready;
  logic                         accept;

  // A tick counts as pending in its own cycle so commands stay closed until the sweep ends.
  assign ready         = (state_q == S_IDLE) && !pend_q && !tick_q && rst;
  assign accept        = cmd.cmd_valid && ready;
  assign cmd.cmd_ready = ready;
  assign cmd.cmd_err   = err_q;
  assign tick_ms       = tick_q;
  assign expired       = expired_q;
  assign active        = act_q;

  always_comb begin
    pre_d     = (pre_q == PRE_MAX) ? '0 : pre_q + PRE_W'(1);
    tick_d    = (pre_q == PRE_MAX);
    pend_d    = pend_q | tick_q;
    state_d   = state_q;
    idx_d     = idx_q;
    act_d     = act_q;
    per_d     = per_q;
    remain_d  = remain_q;
    reload_d  = reload_q;
    expired_d = '0;
    err_d     = accept && (int'(cmd.cmd_ch) >= NUM_CH);

    case (state_q)
      S_IDLE: begin
        if (pend_q || tick_q) begin
          state_d = S_SWEEP;
          idx_d   = '0;
          pend_d  = 1'b0;
        end
      end
      S_SWEEP: begin
        if (idx_q == IDX_MAX) state_d = S_DONE;
        else                  idx_d   = idx_q + IDX_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < NUM_CH; i++) begin
      if (accept && int'(cmd.cmd_ch) == i) begin
        if (!cmd.cmd_op) begin
          act_d[i]    = 1'b1;
          per_d[i]    = cmd.cmd_periodic;
          reload_d[i] = cmd.cmd_ms;
          remain_d[i] = cmd.cmd_ms;
        end else begin
          act_d[i] = 1'b0;
        end
      end
      if (state_q == S_SWEEP && int'(idx_q) == i && act_q[i]) begin
        if (remain_q[i] <= CNT_W'(1)) begin
          expired_d[i] = 1'b1;
          // A zero reload still fires every tick rather than wrapping.
          if (per_q[i]) remain_d[i] = (reload_q[i] == '0) ? CNT_W'(1) : reload_q[i];
          else          act_d[i]    = 1'b0;
        end else begin
          remain_d[i] = remain_q[i] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      tick_q    <= 1'b0;
      pend_q    <= 1'b0;
      idx_q     <= '0;
      act_q     <= '0;
      per_q     <= '0;
      remain_q  <= '0;
      reload_q  <= '0;
      expired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      pend_q    <= pend_d;
      idx_q     <= idx_d;
      act_q     <= act_d;
      per_q     <= per_d;
      remain_q  <= remain_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
      err_q     <= err_d;
    end
  end

`ifdef TIMER_SCHEDULER_UPTIME_EN
  logic [9:0] upms_q, upms_d;
  logic [7:0] ups_q, ups_d;

  assign uptime_ms = upms_q;
  assign uptime_s  = ups_q;

  always_comb begin
    upms_d = upms_q;
    ups_d  = ups_q;
    if (tick_q) begin
      if (upms_q == 10'd999) begin
        upms_d = '0;
        ups_d  = ups_q + 8'd1;
      end else begin
        upms_d = upms_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      upms_q <= '0;
      ups_q  <= '0;
    end else begin
      upms_q <= upms_d;
      ups_q  <= ups_d;
    end
  end
`endif

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler: 10-cycle tick, four channels.
module tb_timer_scheduler;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              tick_ms;
  logic [NUM_CH-1:0] expired;
  logic [NUM_CH-1:0] active;
  int                checks = 0;
  int                errors = 0;
  logic [6:1][3:0]   cap_exp;
  logic [6:1][3:0]   cap_act;

  timer_scheduler_if #(.CNT_W(CNT_W)) cmd_if();

  timer_scheduler #(
    .CLOCK_HZ(10000),
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .cmd    (cmd_if),
    .tick_ms(tick_ms),
    .expired(expired),
    .active (active)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns at the cycle tick_ms is high (immediately if already high).
  task automatic wait_tick();
    int n = 0;
    while (tick_ms !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    if (tick_ms !== 1'b1) chk("tick_timeout", 32'(tick_ms), 1);
  endtask

  // Captures expired/active for cycles T+1..T+6 of the next tick.
  task automatic tick_cap();
    wait_tick();
    for (int k = 1; k <= 6; k++) begin
      cyc();
      cap_exp[k] = expired;
      cap_act[k] = active;
    end
  endtask

  function automatic logic [23:0] pulse(input int k, input logic [3:0] v);
    return 24'(v) << (4 * (k - 1));
  endfunction

  task automatic send(input logic op, input logic [3:0] ch, input logic [15:0] ms,
                      input logic per);
    int n = 0;
    cmd_if.cmd_valid    = 1'b1;
    cmd_if.cmd_op       = op;
    cmd_if.cmd_ch       = ch;
    cmd_if.cmd_ms       = ms;
    cmd_if.cmd_periodic = per;
    while (cmd_if.cmd_ready !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    chk("send_ready", 32'(cmd_if.cmd_ready), 1);
    cyc();
    cmd_if.cmd_valid = 1'b0;
  endtask

  initial begin
    cmd_if.cmd_valid    = 1'b0;
    cmd_if.cmd_op       = 1'b0;
    cmd_if.cmd_ch       = 4'd0;
    cmd_if.cmd_ms       = 16'd0;
    cmd_if.cmd_periodic = 1'b0;

    // Reset values
    cyc(); cyc(); cyc();
    chk("rst_tick", 32'(tick_ms), 0);
    chk("rst_outs", 32'({active, expired}), 0);
    chk("rst_ready", 32'(cmd_if.cmd_ready), 0);
    chk("rst_err", 32'(cmd_if.cmd_err), 0);

    rst = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      chk("pre_first_tick", 32'(tick_ms), 0);
    end
    cyc();
    chk("first_tick", 32'(tick_ms), 1);

    // Idle: tick every 10 cycles, ready low for T..T+5
    for (int j = 0; j < 35; j++) begin
      chk("idle_tick", 32'(tick_ms), ((j % 10) == 0) ? 1 : 0);
      chk("idle_ready", 32'(cmd_if.cmd_ready), ((j % 10) >= 6) ? 1 : 0);
      chk("idle_outs", 32'({active, expired}), 0);
      cyc();
    end

    // One-shot ch2, 3 ms: fires at T+4 of the 3rd tick
    send(1'b0, 4'd2, 16'd3, 1'b0);
    chk("arm2_active", 32'(active), 32'h4);
    for (int t = 1; t <= 2; t++) begin
      tick_cap();
      chk("arm2_quiet", 32'(cap_exp), 0);
      chk("arm2_still_active", 32'(cap_act[6]), 32'h4);
    end
    tick_cap();
    chk("arm2_fire", 32'(cap_exp), 32'(pulse(4, 4'b0100)));
    chk("arm2_act_before", 32'(cap_act[3]), 32'h4);
    chk("arm2_act_drop", 32'(cap_act[4]), 0);
    for (int t = 1; t <= 10; t++) begin
      tick_cap();
      chk("arm2_after", 32'({cap_exp, cap_act}), 0);
    end

    // Periodic ch0 every 2 ms, ch3 with reload 0 every ms
    send(1'b0, 4'd0, 16'd2, 1'b1);
    send(1'b0, 4'd3, 16'd0, 1'b1);
    for (int t = 1; t <= 4; t++) begin
      tick_cap();
      chk("periodic_pulses", 32'(cap_exp),
          ((t % 2) == 0) ? 32'(pulse(2, 4'b0001) | pulse(5, 4'b1000))
                         : 32'(pulse(5, 4'b1000)));
      chk("periodic_active", 32'(cap_act[6]), 32'h9);
    end

    // Cancel both, cancel idle ch2, then cancel/re-arm ch1
    send(1'b1, 4'd0, 16'd0, 1'b0);
    send(1'b1, 4'd3, 16'd0, 1'b0);
    send(1'b1, 4'd2, 16'd0, 1'b0);
    chk("cancel_all", 32'(active), 0);
    send(1'b0, 4'd1, 16'd5, 1'b0);
    for (int t = 1; t <= 2; t++) begin
      tick_cap();
      chk("ch1_first_quiet", 32'(cap_exp), 0);
    end
    send(1'b1, 4'd1, 16'd0, 1'b0);
    chk("ch1_cancelled", 32'(active), 0);
    send(1'b0, 4'd1, 16'd4, 1'b0);
    chk("ch1_rearmed", 32'(active), 32'h2);
    for (int t = 1; t <= 3; t++) begin
      tick_cap();
      chk("ch1_rearm_quiet", 32'(cap_exp), 0);
    end
    tick_cap();
    chk("ch1_fire", 32'(cap_exp), 32'(pulse(3, 4'b0010)));
    chk("ch1_act_drop", 32'(cap_act[3]), 0);
    tick_cap();
    chk("ch1_after", 32'({cap_exp, cap_act}), 0);

    // Out-of-range channel
    chk("err_idle", 32'(cmd_if.cmd_err), 0);
    send(1'b0, 4'd9, 16'd2, 1'b0);
    chk("err_pulse", 32'(cmd_if.cmd_err), 1);
    chk("err_no_state", 32'(active), 0);
    cyc();
    chk("err_single", 32'(cmd_if.cmd_err), 0);

    // Command held across a sweep is taken once, when ready rises
    wait_tick();
    cmd_if.cmd_valid    = 1'b1;
    cmd_if.cmd_op       = 1'b0;
    cmd_if.cmd_ch       = 4'd0;
    cmd_if.cmd_ms       = 16'd1;
    cmd_if.cmd_periodic = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      chk("hold_ready_low", 32'(cmd_if.cmd_ready), 0);
      chk("hold_not_taken", 32'(active), 0);
      cyc();
    end
    chk("hold_ready_high", 32'(cmd_if.cmd_ready), 1);
    cyc();
    cmd_if.cmd_valid = 1'b0;
    chk("hold_taken", 32'(active), 32'h1);
    tick_cap();
    chk("hold_fire", 32'(cap_exp), 32'(pulse(2, 4'b0001)));
    chk("hold_act_drop", 32'(cap_act[2]), 0);
    tick_cap();
    chk("hold_once", 32'({cap_exp, cap_act}), 0);

    // Reset mid-sweep with ch1 and ch2 due
    send(1'b0, 4'd1, 16'd1, 1'b0);
    send(1'b0, 4'd2, 16'd1, 1'b0);
    chk("pre_rst_active", 32'(active), 32'h6);
    wait_tick();
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("midrst_outs", 32'({active, expired}), 0);
    chk("midrst_tick", 32'(tick_ms), 0);
    chk("midrst_ready", 32'(cmd_if.cmd_ready), 0);
    cyc();
    chk("midrst_outs2", 32'({active, expired}), 0);
    rst = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      chk("postrst_quiet", 32'({tick_ms, expired}), 0);
    end
    cyc();
    chk("postrst_tick", 32'(tick_ms), 1);
    tick_cap();
    chk("postrst_no_pulse", 32'({cap_exp, cap_act}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/timer_scheduler.md
Name: timer_scheduler

Overview:
Multi-channel millisecond timer service. It divides clk down to a 1 ms tick and shares that tick among NUM_CH software/hardware requesters through a single command port. On each tick a sequencer sweeps the channels one per cycle, decrements each armed channel, and raises per-channel expiry pulses. It sits beside the free-running time counters and is the only block that arms or cancels timeouts.

Parameters:
CLOCK_HZ, 25000000, clk frequency in Hz. CLOCK_HZ/1000 must be >= NUM_CH+3.
NUM_CH, 4, number of timer channels (1..16).
CNT_W, 16, width of the millisecond count per channel.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  command can be accepted this cycle
cmd_op  in  1  0 = ARM, 1 = CANCEL
cmd_ch  in  4  target channel index
cmd_ms  in  CNT_W  timeout in ms (ARM only)
cmd_periodic  in  1  1 = auto-reload on expiry (ARM only)
cmd_err  out  1  1-cycle pulse: accepted command had cmd_ch >= NUM_CH
tick_ms  out  1  1-cycle pulse per elapsed millisecond
expired  out  NUM_CH  per-channel 1-cycle expiry pulses
active  out  NUM_CH  per-channel armed flag

Behaviour:
- Reset (rst=0 at posedge): prescaler=0, tick_pending=0, FSM=IDLE, sweep index=0. All channel active/periodic/remain/reload=0. Outputs cmd_err, tick_ms, expired, active=0. cmd_ready=0 during reset.
- Prescaler: counts 0..CLOCK_HZ/1000-1 and wraps. tick_ms is a registered pulse, high for the single cycle after the counter reaches its terminal value. It is free-running and never stalls.
- tick_pending: set in the cycle tick_ms=1, cleared when the FSM enters SWEEP.
- Handshake: cmd_ready = (FSM==IDLE) && !tick_pending && rst. Transfer occurs when cmd_valid && cmd_ready. It is applied at that clock edge.
- A command accepted in the same cycle as tick_ms=1 is applied before that tick's sweep.
- ARM: sets active=1, periodic=cmd_periodic, reload=cmd_ms, remain=cmd_ms. Arming an already active channel overwrites it and restarts the count, with no expiry pulse.
- CANCEL: sets active=0 with no pulse. Cancelling an idle channel is a no-op.
- cmd_ch >= NUM_CH: the command is accepted, has no state change, and cmd_err pulses in the next cycle.
- FSM states:
  - IDLE: go to SWEEP when tick_pending=1, with index=0.
  - SWEEP: process channel[index] each cycle. index==NUM_CH-1 -> DONE, else index+1.
  - DONE: go to IDLE (one cycle, cmd_ready stays 0).
- Per-channel processing in SWEEP:
  - If active and remain<=1: expired[index] pulses the next cycle. Then, if periodic, remain=reload, except that reload==0 loads 1, so the channel fires every ms. If not periodic, active=0.
  - If active and remain>1: remain=remain-1.
  - If inactive: nothing.
- Latency: tick_ms high at cycle T. SWEEP starts at T+1. expired[i] is high at cycle T+2+i. cmd_ready returns at T+NUM_CH+2.
- ARM with cmd_ms=0 or 1 expires on the next tick. ARM with N>=1 expires on the Nth tick after acceptance.
- At most one expired bit is set in any cycle.
- Counters never underflow. remain is only decremented when >1.
- Reset mid-sweep: everything returns to its reset value immediately, and no pending expiry pulse is emitted afterwards.

Optional Feature:
- Macro TIMER_SCHEDULER_UPTIME_EN.
- When defined, two extra outputs are added:
  - uptime_ms [9:0]: increments on each tick_ms and wraps 999->0.
  - uptime_s [7:0]: increments when uptime_ms wraps, and wraps 255->0.
  - Both are 0 at reset.
- When undefined, these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Bench uses CLOCK_HZ=10000 (10-cycle tick) and NUM_CH=4 throughout.
- Reset, then idle 35 cycles -> tick_ms pulses exactly every 10 cycles; active=0; expired=0; cmd_ready low only for the 6 cycles starting at each tick.
- ARM ch2, 3 ms, one-shot -> expired[2] is a single pulse at T+4 of the 3rd tick after acceptance; active[2] drops in the same cycle; no further pulses over 10 ticks.
- ARM ch0 periodic 2 ms and ch3 periodic 0 ms -> expired[0] on every 2nd tick, expired[3] on every tick; on shared ticks, bit 0 at T+2 and bit 3 at T+5, never in the same cycle.
- ARM ch1 5 ms; CANCEL ch1 after 2 ticks; re-ARM ch1 4 ms -> no pulse for the cancelled timer; a single pulse 4 ticks after re-arm.
- Command cmd_ch=9 -> cmd_err pulse one cycle later, active unchanged. Hold cmd_valid during a sweep -> accepted only when cmd_ready rises, exactly once.
- Assert rst mid-SWEEP while ch1 and ch2 are due to expire -> no expired pulse; all outputs 0; prescaler restarts, with the first tick 10 cycles after rst is released.
